// File: rtl/var_sched_pkg.sv
// Shared widths and helpers for the variance-datapath scheduler and its tag FIFO.
package var_sched_pkg;

    localparam int unsigned DEF_DATA_W = 1024;
    localparam int unsigned DEF_RES_W  = 32;
    localparam int unsigned CNT_W      = 16;

    // Bits needed to index n entries (never less than one bit).
    function automatic int unsigned tag_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/var_tag_fifo.sv
// In-order FIFO of requester tags for results still owed by the datapath.
module var_tag_fifo
    import var_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [TAG_W-1:0] head
);

    localparam int unsigned PTR_W = tag_w(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Extra pointer MSB distinguishes full from empty.
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/var_sched.sv
// Round-robin scheduler sharing one E[x^2] datapath among NREQ requesters.
// Optional statistics counters are enabled with `define VAR_SCHED_STATS_EN.
module var_sched
    import var_sched_pkg::*;
#(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned RES_W        = DEF_RES_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [NREQ*RES_W-1:0]  rsp_ex2,
    output logic                   dp_in_valid,
    input  logic                   dp_in_ready,
    output logic [DATA_W-1:0]      dp_a_in,
    input  logic [RES_W-1:0]       dp_ex2,
    input  logic                   dp_out_valid,
    output logic                   dp_out_ready,
    output logic                   err
`ifdef VAR_SCHED_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0]  grant_cnt,
    output logic [CNT_W-1:0]       stall_cnt
`endif
);

    localparam int unsigned TAG_W = tag_w(NREQ);
    localparam int unsigned IF_W  = tag_w(MAX_INFLIGHT) + 1;

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] gnt;
    logic [TAG_W-1:0] cand;
    logic [TAG_W-1:0] head;
    logic             found;
    logic             fifo_full;
    logic             fifo_empty;
    logic             in_fire;
    logic             out_fire;
    logic [IF_W-1:0]  inflight;
    logic [NREQ-1:0]  slot_drain;

    // First valid requester at or after rr_ptr, with wrap.
    always_comb begin
        gnt   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = TAG_W'((int'(rr_ptr) + k) % int'(NREQ));
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    assign dp_in_valid = rst_n && (|req_valid) && !fifo_full &&
                         (inflight < IF_W'(MAX_INFLIGHT));
    assign in_fire     = dp_in_valid && dp_in_ready;

    always_comb begin
        dp_a_in   = '0;
        req_ready = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt == TAG_W'(i)) begin
                dp_a_in      = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = in_fire;
            end
        end
    end

    // A slot being consumed this cycle may be refilled on the same edge.
    assign slot_drain   = rsp_valid & rsp_ready;
    assign dp_out_ready = !fifo_empty && (!rsp_valid[head] || slot_drain[head]);
    assign out_fire     = dp_out_valid && dp_out_ready;

    var_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (in_fire),
        .push_tag (gnt),
        .pop      (out_fire),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_ex2   <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (out_fire && (head == TAG_W'(i))) begin
                    rsp_valid[i]               <= 1'b1;
                    rsp_ex2[i*RES_W +: RES_W]  <= dp_ex2;
                end else if (slot_drain[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (in_fire) begin
                rr_ptr <= (gnt == TAG_W'(NREQ - 1)) ? '0 : gnt + TAG_W'(1);
            end
            case ({in_fire, out_fire})
                2'b10:   inflight <= inflight + IF_W'(1);
                2'b01:   inflight <= inflight - IF_W'(1);
                default: inflight <= inflight;
            endcase
            // A result with no owner is dropped and flagged.
            if (dp_out_valid && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

`ifdef VAR_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_ready[i] && (grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
            if ((|req_valid) && !in_fire && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_var_sched.sv
// Directed bench for var_sched with a behavioural E[x^2] datapath stand-in.
module tb_var_sched;

    localparam int NREQ   = 4;
    localparam int DATA_W = 1024;
    localparam int RES_W  = 32;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [NREQ*RES_W-1:0]  rsp_ex2;
    logic                   dp_in_valid;
    logic                   dp_in_ready;
    logic [DATA_W-1:0]      dp_a_in;
    logic [RES_W-1:0]       dp_ex2;
    logic                   dp_out_valid;
    logic                   dp_out_ready;
    logic                   err;

    var_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_ex2      (rsp_ex2),
        .dp_in_valid  (dp_in_valid),
        .dp_in_ready  (dp_in_ready),
        .dp_a_in      (dp_a_in),
        .dp_ex2       (dp_ex2),
        .dp_out_valid (dp_out_valid),
        .dp_out_ready (dp_out_ready),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [NREQ-1:0] rv;
        logic            rdy;
        logic            exp_v;
        logic [NREQ-1:0] exp_rr;
    } vec_t;

    vec_t              tbl [11];
    logic [15:0]       row_val [NREQ];
    logic [RES_W-1:0]  dp_q [$];
    logic [RES_W-1:0]  rsp_log [$];
    logic              dp_en;
    logic              inj;
    int                n_tests;
    int                n_fail;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Mean of squared signed Q8.8 lanes, in Q16.16.
    function automatic logic [RES_W-1:0] ex2_of(input logic [DATA_W-1:0] row);
        longint s;
        longint v;
        logic [15:0] lane;
        s = 0;
        for (int j = 0; j < DATA_W/16; j++) begin
            lane = row[j*16 +: 16];
            v = longint'($signed(lane));
            s += v * v;
        end
        return RES_W'(s >>> 6);
    endfunction

    task automatic set_row(input int r, input logic [15:0] v);
        row_val[r] = v;
        for (int j = 0; j < DATA_W/16; j++) begin
            req_data[r*DATA_W + j*16 +: 16] = v;
        end
    endtask

    task automatic drive_dp();
        dp_out_valid = inj || (dp_en && (dp_q.size() > 0));
        dp_ex2       = (dp_q.size() > 0) ? dp_q[0] : '0;
    endtask

    task automatic half_a();
        @(negedge clk);
    endtask

    task automatic finish_cycle();
        if (dp_out_valid && dp_out_ready && (dp_q.size() > 0)) begin
            void'(dp_q.pop_front());
        end
        if (dp_in_valid && dp_in_ready) begin
            dp_q.push_back(ex2_of(dp_a_in));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
                rsp_log.push_back(rsp_ex2[i*RES_W +: RES_W]);
            end
        end
        @(posedge clk);
        #1;
        drive_dp();
    endtask

    task automatic cycle();
        half_a();
        finish_cycle();
    endtask

    logic [DATA_W-1:0] exp_row;
    int                gidx;
    int                grants;
    bit                seen;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        dp_en   = 1'b1;
        inj     = 1'b0;
        req_data = '0;
        set_row(0, 16'h0200);
        set_row(1, 16'h0180);
        set_row(2, 16'h0100);
        set_row(3, 16'h0080);
        dp_in_ready  = 1'b1;
        rsp_ready    = '1;
        req_valid    = 4'b1111;
        dp_out_valid = 1'b0;
        dp_ex2       = '0;
        rst_n        = 1'b0;

        // Reset: requests present but nothing may be granted.
        repeat (10) cycle();
        half_a();
        chk("rst req_ready",    64'(req_ready),    64'h0);
        chk("rst rsp_valid",    64'(rsp_valid),    64'h0);
        chk("rst rsp_ex2",      64'(|rsp_ex2),     64'h0);
        chk("rst dp_in_valid",  64'(dp_in_valid),  64'h0);
        chk("rst dp_out_ready", 64'(dp_out_ready), 64'h0);
        chk("rst err",          64'(err),          64'h0);
        finish_cycle();
        rst_n     = 1'b1;
        req_valid = '0;
        cycle();

        tbl[0]  = '{4'b1111, 1'b1, 1'b1, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001};
        tbl[5]  = '{4'b1001, 1'b1, 1'b1, 4'b1000};
        tbl[6]  = '{4'b1001, 1'b0, 1'b1, 4'b0000};
        tbl[7]  = '{4'b0110, 1'b1, 1'b1, 4'b0010};
        tbl[8]  = '{4'b0010, 1'b1, 1'b1, 4'b0010};
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000};
        tbl[10] = '{4'b0001, 1'b1, 1'b1, 4'b0001};

        for (int t = 0; t < 11; t++) begin
            req_valid   = tbl[t].rv;
            dp_in_ready = tbl[t].rdy;
            half_a();
            chk($sformatf("rr%0d dp_in_valid", t), 64'(dp_in_valid), 64'(tbl[t].exp_v));
            chk($sformatf("rr%0d req_ready", t),   64'(req_ready),   64'(tbl[t].exp_rr));
            if (tbl[t].exp_rr != '0) begin
                gidx = 0;
                for (int i = 0; i < NREQ; i++) begin
                    if (tbl[t].exp_rr[i]) gidx = i;
                end
                exp_row = {(DATA_W/16){row_val[gidx]}};
                n_tests++;
                if (dp_a_in !== exp_row) begin
                    n_fail++;
                    $display("FAIL rr%0d dp_a_in: got %h expected %h", t, dp_a_in[31:0], exp_row[31:0]);
                end
            end
            finish_cycle();
        end
        req_valid   = '0;
        dp_in_ready = 1'b1;
        repeat (10) cycle();

        // Routing: a single row of 1.0 from requester 2.
        rsp_ready = '0;
        req_valid = 4'b0100;
        half_a();
        chk("route req_ready", 64'(req_ready), 64'h4);
        finish_cycle();
        req_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            half_a();
            if (rsp_valid[2]) seen = 1'b1;
            else finish_cycle();
        end
        chk("route seen",      64'(seen),                   64'h1);
        chk("route rsp_valid", 64'(rsp_valid),              64'h4);
        chk("route rsp_ex2",   64'(rsp_ex2[2*RES_W +: RES_W]), 64'h0001_0000);
        finish_cycle();
        rsp_ready = 4'b0100;
        cycle();
        half_a();
        chk("route drained", 64'(rsp_valid), 64'h0);
        finish_cycle();

        // Backpressure on slot 1 with two results owed to requester 1.
        rsp_ready = '0;
        rsp_log.delete();
        set_row(1, 16'h0100);
        req_valid = 4'b0010;
        half_a();
        chk("bp fire0", 64'(req_ready), 64'h2);
        finish_cycle();
        set_row(1, 16'h0200);
        half_a();
        chk("bp fire1",       64'(req_ready),    64'h2);
        chk("bp first ready", 64'(dp_out_ready), 64'h1);
        finish_cycle();
        req_valid = '0;
        half_a();
        chk("bp stall valid", 64'(dp_out_valid), 64'h1);
        chk("bp stall ready", 64'(dp_out_ready), 64'h0);
        chk("bp slot1 valid", 64'(rsp_valid),    64'h2);
        chk("bp slot1 data",  64'(rsp_ex2[1*RES_W +: RES_W]), 64'h0001_0000);
        finish_cycle();
        cycle();
        half_a();
        chk("bp still stalled", 64'(dp_out_ready), 64'h0);
        finish_cycle();
        rsp_ready = 4'b0010;
        half_a();
        chk("bp drain+refill ready", 64'(dp_out_ready), 64'h1);
        finish_cycle();
        rsp_ready = '0;
        half_a();
        chk("bp refill valid", 64'(rsp_valid[1]), 64'h1);
        chk("bp refill data",  64'(rsp_ex2[1*RES_W +: RES_W]), 64'h0004_0000);
        chk("bp dp idle",      64'(dp_out_valid), 64'h0);
        finish_cycle();
        rsp_ready = 4'b0010;
        cycle();
        half_a();
        chk("bp empty", 64'(rsp_valid), 64'h0);
        finish_cycle();
        chk("bp log count", 64'(rsp_log.size()), 64'd2);
        if (rsp_log.size() == 2) begin
            chk("bp log0", 64'(rsp_log[0]), 64'h0001_0000);
            chk("bp log1", 64'(rsp_log[1]), 64'h0004_0000);
        end

        // Inflight cap: the datapath holds every result.
        rsp_ready = '1;
        dp_en     = 1'b0;
        drive_dp();
        req_valid = 4'b1111;
        grants    = 0;
        for (int c = 0; c < 12; c++) begin
            half_a();
            if (|req_ready) grants++;
            finish_cycle();
        end
        half_a();
        chk("cap grants",      64'(grants),      64'd8);
        chk("cap dp_in_valid", 64'(dp_in_valid), 64'h0);
        chk("cap req_ready",   64'(req_ready),   64'h0);
        finish_cycle();
        req_valid = '0;
        dp_en     = 1'b1;
        drive_dp();
        repeat (30) cycle();
        half_a();
        chk("cap drained ready", 64'(dp_out_ready), 64'h0);
        chk("cap drained rsp",   64'(rsp_valid),    64'h0);
        finish_cycle();

        // Orphan result raises a sticky error.
        inj = 1'b1;
        drive_dp();
        half_a();
        chk("err dp_out_ready", 64'(dp_out_ready), 64'h0);
        chk("err before edge",  64'(err),          64'h0);
        inj = 1'b0;
        finish_cycle();
        half_a();
        chk("err set",       64'(err),       64'h1);
        chk("err no result", 64'(rsp_valid), 64'h0);
        finish_cycle();
        repeat (5) cycle();
        half_a();
        chk("err sticky", 64'(err), 64'h1);
        finish_cycle();
        rst_n = 1'b0;
        dp_q.delete();
        drive_dp();
        half_a();
        chk("err cleared", 64'(err), 64'h0);
        finish_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
